// File: rtl/spi_master_apb_pkg.sv
// Register map, CTRL/STATUS field positions and FSM state encoding for the APB SPI master.
// Pure definitions: no logic and no added latency.
// Shared by the register block and the frame controller, so they decode one common map.
package spi_master_apb_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_TXDATA = 8'h08;
    localparam logic [7:0] ADDR_RXDATA = 8'h0C;
    localparam logic [7:0] ADDR_CLKDIV = 8'h10;

    localparam int CTRL_START   = 0;
    localparam int CTRL_INT_EN  = 1;
    localparam int CTRL_LEN_LSB = 8;
    localparam int CTRL_LEN_MSB = 12;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_HI = 3'd2,
        ST_SCK_LO = 3'd3,
        ST_HOLD   = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_master_apb_reg.sv
// APB register file: CTRL/STATUS/TXDATA/RXDATA/CLKDIV decode, START qualification and interrupt.
// Writes land on the psel&penable&pwrite edge; reads are combinational.
// No wait states; a START that arrives while a frame is running is dropped.
module spi_master_apb_reg
    import spi_master_apb_pkg::*;
#(
    parameter logic [7:0] CLKDIV_RST = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    input  logic        busy,
    input  logic        done_set,
    input  logic [31:0] rx_data,
    output logic        start,
    output logic [4:0]  start_len,
    output logic [7:0]  clkdiv,
    output logic [31:0] txdata,
    output logic        irq
);

    logic        wr, wr_ctrl, wr_stat, wr_tx, wr_div;
    logic        int_en, done;
    logic [4:0]  len_q;
    logic [31:0] rxdata;

    assign wr      = psel & penable & pwrite;
    assign wr_ctrl = wr && (paddr == ADDR_CTRL);
    assign wr_stat = wr && (paddr == ADDR_STATUS);
    assign wr_tx   = wr && (paddr == ADDR_TXDATA);
    assign wr_div  = wr && (paddr == ADDR_CLKDIV);

    // LEN written together with START is the one the frame uses.
    assign start     = wr_ctrl && pwdata[CTRL_START] && !busy;
    assign start_len = pwdata[CTRL_LEN_MSB:CTRL_LEN_LSB];
    assign irq       = done & int_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_en <= 1'b0;
            len_q  <= '0;
            done   <= 1'b0;
            txdata <= '0;
            rxdata <= '0;
            clkdiv <= CLKDIV_RST;
        end else begin
            if (wr_ctrl) begin
                int_en <= pwdata[CTRL_INT_EN];
                len_q  <= pwdata[CTRL_LEN_MSB:CTRL_LEN_LSB];
            end
            if (wr_tx)
                txdata <= pwdata;
            if (wr_div)
                clkdiv <= pwdata[7:0];
            // Completion beats a simultaneous W1C.
            if (done_set) begin
                done   <= 1'b1;
                rxdata <= rx_data;
            end else if (start || (wr_stat && pwdata[STAT_DONE])) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (paddr)
                ADDR_CTRL:   prdata = {19'b0, len_q, 6'b0, int_en, 1'b0};
                ADDR_STATUS: prdata = {30'b0, done, busy};
                ADDR_TXDATA: prdata = txdata;
                ADDR_RXDATA: prdata = rxdata;
                ADDR_CLKDIV: prdata = {24'b0, clkdiv};
                default:     prdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 frame engine: FSM, half-period counter, bit counter, TX/RX shift registers.
// csb drops the edge after START; frame is H*(2*(LEN+1)+1) cycles with H = CLKDIV+1.
// Ignores start while busy; reports completion with a one-cycle done_set.
module spi_master_ctrl
    import spi_master_apb_pkg::*;
#(
    parameter  int MAX_LEN = 32,
    localparam int LW      = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LW-1:0]      len,
    input  logic [7:0]         clkdiv,
    input  logic [MAX_LEN-1:0] txdata,
    input  logic               sdi,
    output logic               busy,
    output logic               done_set,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               csb,
    output logic               sclk,
    output logic               sdo
);

    spi_state_t         state, next_state;
    logic [7:0]         div_q, cnt;
    logic [LW-1:0]      bit_cnt;
    logic [MAX_LEN-1:0] tx_sh, rx_sh;
    logic               tick;

    assign tick     = (cnt == div_q);
    assign busy     = (state != ST_IDLE);
    assign done_set = (state == ST_HOLD) && tick;
    assign rx_data  = rx_sh;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SETUP;
            ST_SETUP:  if (tick)  next_state = ST_SCK_HI;
            // After the last high phase the final low phase is the HOLD.
            ST_SCK_HI: if (tick)  next_state = (bit_cnt != '0) ? ST_SCK_LO : ST_HOLD;
            ST_SCK_LO: if (tick)  next_state = ST_SCK_HI;
            ST_HOLD:   if (tick)  next_state = ST_IDLE;
            default:              next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_q   <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            csb     <= 1'b1;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            csb  <= (next_state == ST_IDLE);
            sclk <= (next_state == ST_SCK_HI);
            cnt  <= (state == ST_IDLE || tick) ? 8'd0 : cnt + 8'd1;
            if (state == ST_IDLE && start) begin
                // Left-align the frame so the next bit out is always the MSB.
                div_q   <= clkdiv;
                bit_cnt <= len;
                tx_sh   <= txdata << (LW'(MAX_LEN - 1) - len);
                sdo     <= txdata[len];
                rx_sh   <= '0;
            end else if (tick) begin
                if (next_state == ST_SCK_HI)
                    rx_sh <= {rx_sh[MAX_LEN-2:0], sdi};
                if (next_state == ST_SCK_LO) begin
                    tx_sh   <= tx_sh << 1;
                    sdo     <= tx_sh[MAX_LEN-2];
                    bit_cnt <= bit_cnt - LW'(1);
                end
                if (next_state == ST_IDLE)
                    sdo <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master_apb.sv
// APB-programmable SPI master (mode 0, MSB first, 1..32-bit frames) with a level interrupt.
// Register writes take one edge; csb falls on the edge that accepts START.
// APB never stalls; START during a running frame is ignored.
module spi_master_apb
    import spi_master_apb_pkg::*;
#(
    parameter logic [7:0] CLKDIV_RST = 8'd3,
    parameter int         MAX_LEN    = 32
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [31:0] apb_spi_paddr,
    input  logic        apb_spi_psel,
    input  logic        apb_spi_penable,
    input  logic        apb_spi_pwrite,
    input  logic [31:0] apb_spi_pwdata,
    output logic [31:0] spi_apb_prdata,
    output logic        csb,
    output logic        sclk,
    output logic        sdo,
    input  logic        sdi,
    output logic        spi_vic_int
);

    localparam int LW = $clog2(MAX_LEN);

    logic               busy, done_set, start;
    logic [4:0]         start_len;
    logic [7:0]         clkdiv;
    logic [31:0]        txdata;
    logic [MAX_LEN-1:0] rx_data;
    logic               unused_paddr;

    assign unused_paddr = ^apb_spi_paddr[31:8];

    spi_master_apb_reg #(
        .CLKDIV_RST (CLKDIV_RST)
    ) u_reg (
        .clk       (sys_clk),
        .rst       (rst),
        .paddr     (apb_spi_paddr[7:0]),
        .psel      (apb_spi_psel),
        .penable   (apb_spi_penable),
        .pwrite    (apb_spi_pwrite),
        .pwdata    (apb_spi_pwdata),
        .prdata    (spi_apb_prdata),
        .busy      (busy),
        .done_set  (done_set),
        .rx_data   (32'(rx_data)),
        .start     (start),
        .start_len (start_len),
        .clkdiv    (clkdiv),
        .txdata    (txdata),
        .irq       (spi_vic_int)
    );

    spi_master_ctrl #(
        .MAX_LEN (MAX_LEN)
    ) u_ctrl (
        .clk      (sys_clk),
        .rst      (rst),
        .start    (start),
        .len      (start_len[LW-1:0]),
        .clkdiv   (clkdiv),
        .txdata   (txdata[MAX_LEN-1:0]),
        .sdi      (sdi),
        .busy     (busy),
        .done_set (done_set),
        .rx_data  (rx_data),
        .csb      (csb),
        .sclk     (sclk),
        .sdo      (sdo)
    );

endmodule
